// File: rtl/regfile_pkg.sv
// Shared constants and bus-slicing helper for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned ADDR_ZERO  = 0;

    // Widest bus and widest slice the helper can handle.
    localparam int unsigned BUS_MAX    = 256;
    localparam int unsigned SLICE_MAX  = 64;

    function automatic logic [SLICE_MAX-1:0] get_slice(
        input logic [BUS_MAX-1:0] bus,
        input int unsigned        k,
        input int unsigned        w
    );
        logic [BUS_MAX-1:0] mask;
        logic [BUS_MAX-1:0] shifted;
        mask    = {BUS_MAX{1'b1}} >> (BUS_MAX - w);
        shifted = (bus >> (k * w)) & mask;
        return shifted[SLICE_MAX-1:0];
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared by writeback, bulk-cleared on flush.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_en,
    input  logic [ADDR_W-1:0]    set_addr,
    input  logic                 clr0_en,
    input  logic [ADDR_W-1:0]    clr0_addr,
    input  logic                 clr1_en,
    input  logic [ADDR_W-1:0]    clr1_addr,
    input  logic                 flush,
    output logic [2**ADDR_W-1:0] busy
);

    logic [2**ADDR_W-1:0] busy_nxt;

    // Clears are applied first so a same-cycle issue (the younger event) wins.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (clr0_en) busy_nxt[clr0_addr] = 1'b0;
            if (clr1_en) busy_nxt[clr1_addr] = 1'b0;
        end
        if (set_en) busy_nxt[set_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[ADDR_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) busy <= '0;
        else       busy <= busy_nxt;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: N_RD combinational read ports with write-through
// bypass, two prioritised write ports (wr1 wins) and an issue scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_RD*ADDR_W-1:0] rd_addr,
    output logic [N_RD*DATA_W-1:0] rd_data,
    output logic [N_RD-1:0]        rd_busy,
    input  logic                   wr0_en,
    input  logic [ADDR_W-1:0]      wr0_addr,
    input  logic [DATA_W-1:0]      wr0_data,
    input  logic                   wr1_en,
    input  logic [ADDR_W-1:0]      wr1_addr,
    input  logic [DATA_W-1:0]      wr1_data,
    input  logic                   iss_en,
    input  logic [ADDR_W-1:0]      iss_addr,
    input  logic                   flush
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] A0 = ADDR_W'(ADDR_ZERO);

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]   busy;
    logic               wr0_ok;
    logic               wr1_ok;
    logic [BUS_MAX-1:0] rd_addr_bus;

    assign wr0_ok      = wr0_en && !((ZERO_REG != 0) && (wr0_addr == A0));
    assign wr1_ok      = wr1_en && !((ZERO_REG != 0) && (wr1_addr == A0));
    assign rd_addr_bus = BUS_MAX'(rd_addr);

    // wr1 is applied last so it overwrites wr0 on an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr0_ok) mem[wr0_addr] <= wr0_data;
            if (wr1_ok) mem[wr1_addr] <= wr1_data;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_en    (iss_en),
        .set_addr  (iss_addr),
        .clr0_en   (wr0_en),
        .clr0_addr (wr0_addr),
        .clr1_en   (wr1_en),
        .clr1_addr (wr1_addr),
        .flush     (flush),
        .busy      (busy)
    );

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              hit0;
        logic              hit1;

        assign a    = ADDR_W'(get_slice(rd_addr_bus, k, ADDR_W));
        assign hit0 = wr0_en && (wr0_addr == a);
        assign hit1 = wr1_en && (wr1_addr == a);

        always_comb begin
            if ((ZERO_REG != 0) && (a == A0)) d = '0;
            else if (hit1)                    d = wr1_data;
            else if (hit0)                    d = wr0_data;
            else                              d = mem[a];
        end

        assign rd_data[k*DATA_W +: DATA_W] = d;
        assign rd_busy[k]                  = busy[a] && !(hit0 || hit1);
    end

endmodule
